// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for a VGA-style display. A pixel position
// (pixel_x, pixel_y) walks the full raster (visible area, front porch, sync
// and back porch) one step per clk cycle in which clk_en is high. Sync and
// active flags are registered alongside the position so they always describe
// the pixel currently presented. Pulse outputs mark the first cycle of a new
// line, a new frame and the start of vertical blanking. An 8-bit frame counter
// steps at the start of each vertical blanking interval.
//
// Ports
//   clk          in   pixel clock
//   rst_n        in   synchronous active-low reset (wins over clk_en)
//   clk_en       in   advance the raster position by one pixel
//   pixel_x      out  current column, 0 .. H_TOTAL-1
//   pixel_y      out  current row, 0 .. V_TOTAL-1
//   hsync        out  horizontal sync, SYNC_ACTIVE while asserted
//   vsync        out  vertical sync, SYNC_ACTIVE while asserted
//   active       out  1 while the presented pixel lies in the visible area
//   line_start   out  1-cycle pulse after the step onto column 0
//   frame_start  out  1-cycle pulse after the step onto (0,0)
//   vblank_start out  1-cycle pulse after the step onto (0,V_VISIBLE)
//   frame_count  out  frame number, steps with vblank_start, wraps at 256
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACTIVE = 1'b0,
    localparam int H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int XW         = $clog2(H_TOTAL),
    localparam int YW         = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    output logic [XW-1:0] pixel_x,
    output logic [YW-1:0] pixel_y,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start,
    output logic [7:0]    frame_count
);

    // Last legal counter values.
    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

    // Region boundaries carry one extra bit so an end boundary equal to the
    // total still fits even when the total is a power of two.
    localparam logic [XW:0] X_VIS    = (XW+1)'(H_VISIBLE);
    localparam logic [XW:0] HS_BEGIN = (XW+1)'(H_VISIBLE + H_FRONT);
    localparam logic [XW:0] HS_END   = (XW+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [YW:0] Y_VIS    = (YW+1)'(V_VISIBLE);
    localparam logic [YW:0] VS_BEGIN = (YW+1)'(V_VISIBLE + V_FRONT);
    localparam logic [YW:0] VS_END   = (YW+1)'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [XW-1:0] pixel_x_q,      pixel_x_d;
    logic [YW-1:0] pixel_y_q,      pixel_y_d;
    logic          hsync_q,        hsync_d;
    logic          vsync_q,        vsync_d;
    logic          active_q,       active_d;
    logic          line_start_q,   line_start_d;
    logic          frame_start_q,  frame_start_d;
    logic          vblank_start_q, vblank_start_d;
    logic [7:0]    frame_count_q,  frame_count_d;

    logic          x_wrap;
    logic          y_wrap;

    // Next position first; every flag is then derived from that next
    // position so flags and position land in the same register update.
    always_comb begin
        x_wrap    = clk_en && (pixel_x_q == X_LAST);
        y_wrap    = x_wrap && (pixel_y_q == Y_LAST);
        pixel_x_d = pixel_x_q;
        pixel_y_d = pixel_y_q;

        if (clk_en) begin
            if (x_wrap) begin
                pixel_x_d = '0;
                pixel_y_d = y_wrap ? '0 : pixel_y_q + YW'(1);
            end else begin
                pixel_x_d = pixel_x_q + XW'(1);
            end
        end

        hsync_d  = (({1'b0, pixel_x_d} >= HS_BEGIN) && ({1'b0, pixel_x_d} < HS_END))
                   ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d  = (({1'b0, pixel_y_d} >= VS_BEGIN) && ({1'b0, pixel_y_d} < VS_END))
                   ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        active_d = ({1'b0, pixel_x_d} < X_VIS) && ({1'b0, pixel_y_d} < Y_VIS);

        // Pulses only follow an advancing edge, so they collapse to 0
        // whenever clk_en is low.
        line_start_d   = x_wrap;
        frame_start_d  = y_wrap;
        vblank_start_d = x_wrap && ({1'b0, pixel_y_d} == Y_VIS);

        frame_count_d  = vblank_start_d ? frame_count_q + 8'd1 : frame_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Parked on the last pixel so the first advance lands on (0,0)
            // and raises line_start/frame_start.
            pixel_x_q      <= X_LAST;
            pixel_y_q      <= Y_LAST;
            hsync_q        <= ~SYNC_ACTIVE;
            vsync_q        <= ~SYNC_ACTIVE;
            active_q       <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_count_q  <= 8'd0;
        end else begin
            pixel_x_q      <= pixel_x_d;
            pixel_y_q      <= pixel_y_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            active_q       <= active_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign pixel_x      = pixel_x_q;
    assign pixel_y      = pixel_y_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign active       = active_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;
    assign frame_count  = frame_count_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters: H_VISIBLE 640 (visible columns); H_FRONT 16, H_SYNC 96, H_BACK 48 (horizontal porch and sync, in pixels); V_VISIBLE 480 (visible rows); V_FRONT 10, V_SYNC 2, V_BACK 33 (vertical porch and sync, in lines); SYNC_ACTIVE 0 (asserted level of hsync/vsync).
REQ-002 SHALL derive H_TOTAL = sum of the four horizontal parameters (default 800), V_TOTAL = sum of the four vertical parameters (default 525), XW = clog2(H_TOTAL), YW = clog2(V_TOTAL).
REQ-003 SHALL have ports: clk in 1 (clock); rst_n in 1 (reset); clk_en in 1 (pixel advance enable); pixel_x out XW (current column); pixel_y out YW (current row); hsync out 1; vsync out 1; active out 1 (current pixel is visible); line_start out 1 (pulse); frame_start out 1 (pulse); vblank_start out 1 (pulse); frame_count out 8 (animation frame number).
REQ-004 Reset is rst_n, synchronous, active-low; clock is clk.

Function
REQ-005 Position SHALL be held in registers pixel_x/pixel_y and advance only on clk rising edges with clk_en=1.
REQ-006 Advance rule: pixel_x+1; at pixel_x=H_TOTAL-1, pixel_x->0 and pixel_y+1; at (H_TOTAL-1, V_TOTAL-1), the position wraps to (0,0).
REQ-007 hsync, vsync, active SHALL be registered and always consistent with the presented pixel_x/pixel_y (no one-cycle skew); no combinational path from any input to any output.
REQ-008 hsync = SYNC_ACTIVE iff H_VISIBLE+H_FRONT <= pixel_x < H_VISIBLE+H_FRONT+H_SYNC (default 656..751), else ~SYNC_ACTIVE.
REQ-009 vsync = SYNC_ACTIVE iff V_VISIBLE+V_FRONT <= pixel_y < V_VISIBLE+V_FRONT+V_SYNC (default rows 490..491, for all columns of those rows), else ~SYNC_ACTIVE.
REQ-010 active = 1 iff pixel_x < H_VISIBLE and pixel_y < V_VISIBLE.
REQ-011 line_start SHALL be 1 for exactly one clk cycle: the cycle after an advancing edge that moves pixel_x to 0.
REQ-012 frame_start SHALL be 1 for exactly one clk cycle: the cycle after an advancing edge that moves the position to (0,0).
REQ-013 vblank_start SHALL be 1 for exactly one clk cycle: the cycle after an advancing edge that moves the position to (0, V_VISIBLE); on that same edge frame_count SHALL increment, modulo 256 (255->0).
REQ-014 Pulses SHALL be 0 in every cycle not immediately following an advancing edge; clk_en=0 SHALL hold every registered output except pulses, which drop to 0.
REQ-015 Arithmetic SHALL be unsigned; the counters never take values >= H_TOTAL / V_TOTAL.

Reset
REQ-016 While rst_n=0 at a clk edge: pixel_x=H_TOTAL-1, pixel_y=V_TOTAL-1, hsync=vsync=~SYNC_ACTIVE, active=0, all pulses 0, frame_count=0. Reset overrides clk_en.
REQ-017 Reset asserted mid-frame SHALL take effect at the next clk edge with no residual pulse.
REQ-018 The first advancing edge after reset SHALL present (0,0) with active=1, line_start=1, frame_start=1, frame_count=0.

Verification
REQ-019 Reset, release, clk_en=1 -> first post-release edge gives pixel (0,0), frame_start=line_start=active=1, frame_count=0; the next edge gives pixel (1,0) and both pulses 0.
REQ-020 clk_en=1 continuously over one line -> hsync=0 for exactly 96 cycles from pixel_x=656 to 751; active=0 from pixel_x=640; line_start period is 800 cycles.
REQ-021 Full frame -> vsync=0 for exactly 1600 consecutive cycles, covering rows 490-491; frame_start period is 420000 cycles; vblank_start coincides with (0,480) and frame_count goes 0->1.
REQ-022 clk_en toggled 1,0,0,1 with pixel_x=798 before the first 1 -> pixel_x=799 held for 3 cycles, then 0 with line_start=1 for one cycle only.
REQ-023 Drive 256 frames (or force frame_count via reset plus fast parameters H_TOTAL=8, V_TOTAL=6) -> frame_count wraps 255->0 at vblank_start.
REQ-024 rst_n=0 for one cycle at pixel (300,200) -> next cycle matches the REQ-016 values; the scenario REQ-019 then repeats.
